cla_slice_sequencer: RTL and testbench
======================================

Name: cla_slice_sequencer

Overview:
Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice, built on the existing 4-bit pgu propagate/generate unit. The block latches the operands on a start handshake and feeds one nibble per cycle, LSB first, through the slice. It chains the carry between nibbles and assembles the sum. It sits between the project's operand registers and result bus as the sequencer for the shared pgu/CLA datapath.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4
NSLICE, WIDTH/4, derived (localparam) number of 4-bit slice passes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an add; sampled only when busy=0
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while a slice pass is in progress
done  output  1  one-cycle pulse: sum/cout/ovf valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  carry out of MSB
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, slice index=0, carry reg=0, busy=0, done=0, sum=0, cout=0, ovf=0. An in-flight operation is discarded and done never pulses for it.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE/DONE + start=1 at edge: latch a, b and cin into operand registers and carry reg. Clear sum, cout and ovf. Set idx=0 and go to RUN.
- DONE + start=0: go to IDLE. Back-to-back starts from DONE are legal, giving a throughput of one add per NSLICE+1 cycles.
- RUN, each edge: the slice takes nibble idx of the latched A/B plus the carry reg. It computes p=a^b and g=a&b (pgu), then c1..c4 by lookahead and s=p^{c3..c0}.
  - Write s into sum[4*idx+3:4*idx] and set carry reg=c4.
  - If idx==NSLICE-1: cout=c4, ovf=c3^c4, go to DONE. Otherwise idx=idx+1.
- start while busy=1 is ignored: no restart and no queueing. Changes on a, b and cin after acceptance do not affect the result.
- Latency: start accepted at edge E0 -> done=1 in the cycle after edge E0+NSLICE. For WIDTH=16, done is high in the 5th cycle after the start edge.
- sum/cout/ovf remain stable from DONE until the next accepted start. Partially written sum bits are visible during RUN but are undefined for consumers.
- All arithmetic is modulo 2^WIDTH. Carry reg is 1 bit; idx width is $clog2(NSLICE), minimum 1.

Decomposition:
- Shared package cla_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and SLICE_W=4.
- Sub-module cla4_slice: combinational, instantiates pgu and produces s[3:0], c3 and c4 from a[3:0], b[3:0] and cin. The sequencer holds all registers and the FSM.

Test Plan:
- Reset with rst=1 -> busy=0, done=0, sum=0, cout=0, ovf=0. Release, idle 3 cycles -> no done pulse.
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. done pulses exactly once, in the 5th cycle after the start edge; busy high for 4 cycles.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then back-to-back from DONE: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
- a=0x1234, b=0x4321, cin=0 accepted. During RUN, drive a=0xFFFF, b=0xFFFF and pulse start -> sum=0x5555, cout=0, single done, no restart.
- Start a=0x00F0, b=0x0F10 and assert rst during the 2nd RUN cycle -> outputs zero immediately, no done. After release, a=0x00F0, b=0x0F10 -> sum=0x1000, cout=0.
- Random: 200 operand pairs with random cin at WIDTH=16 and WIDTH=8. Check {cout,sum}==a+b+cin and ovf against the signed reference.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the sequenced carry-lookahead adder datapath.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_slice_sequencer_cla4_slice.sv
// 4-bit propagate/generate unit and the combinational carry-lookahead slice built on it.
module pgu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p,
  output logic [3:0] g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  pgu u_pgu (
    .a (a),
    .b (b),
    .p (p),
    .g (g)
  );

  // Every carry is flattened to sum-of-products of p/g and cin, with no ripple between bits.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per cycle, LSB first, through a shared CLA slice.
module cla_slice_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c3;
  logic               slice_c4;
  logic               accept;
  logic               last;

  cla4_slice u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .s   (slice_s),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  assign accept = (state_q != RUN) && start;
  assign last   = (idx_q == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nibble mux and sum write-back use a constant-index loop so each slot is a plain compare.
  always_comb begin
    a_nib   = '0;
    b_nib   = '0;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*SLICE_W +: SLICE_W];
        b_nib = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (idx_q == IDX_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = slice_s;
      end
      carry_d = slice_c4;
      if (last) begin
        cout_d = slice_c4;
        ovf_d  = slice_c3 ^ slice_c4;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Directed and random checks of the sequenced CLA adder at WIDTH=16 and WIDTH=8.
module tb_cla_slice_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        busy8;
  logic        done8;
  logic [7:0]  sum8;
  logic        cout8;
  logic        ovf8;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  cla_slice_sequencer #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  cla_slice_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents operands with start high for exactly one edge.
  task automatic apply_stimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after the start edge; lat=0 means done never came.
  task automatic wait_done(output int lat, output int busy_cnt);
    int k;
    k = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      k++;
    end
    lat = (done === 1'b1) ? k : 0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int bc;
    apply_stimulus(v.a, v.b, v.cin);
    wait_done(lat, bc);
    check_output({v.name, " latency"}, lat, 5);
    check_output({v.name, " busy cycles"}, bc, 4);
    check_output({v.name, " sum"}, {16'h0, sum}, {16'h0, v.exp_sum});
    check_output({v.name, " cout"}, {31'h0, cout}, {31'h0, v.exp_cout});
    check_output({v.name, " ovf"}, {31'h0, ovf}, {31'h0, v.exp_ovf});
    tick();
    check_output({v.name, " done single pulse"}, {31'h0, done}, 32'h0);
  endtask

  task automatic run_rand16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    logic [16:0] exp;
    logic        exp_ovf;
    int          lat;
    int          bc;
    exp     = {1'b0, av} + {1'b0, bv} + {16'h0, cv};
    exp_ovf = (av[15] == bv[15]) && (exp[15] != av[15]);
    apply_stimulus(av, bv, cv);
    wait_done(lat, bc);
    check_output("rand16 latency", lat, 5);
    check_output("rand16 {cout,sum}", {15'h0, cout, sum}, {15'h0, exp});
    check_output("rand16 ovf", {31'h0, ovf}, {31'h0, exp_ovf});
  endtask

  task automatic run_rand8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    logic [8:0] exp;
    logic       exp_ovf;
    int         k;
    exp     = {1'b0, av} + {1'b0, bv} + {8'h0, cv};
    exp_ovf = (av[7] == bv[7]) && (exp[7] != av[7]);
    a8     = av;
    b8     = bv;
    cin8   = cv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    k = 1;
    while (done8 !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check_output("rand8 latency", (done8 === 1'b1) ? k : 0, 3);
    check_output("rand8 {cout,sum}", {23'h0, cout8, sum8}, {23'h0, exp});
    check_output("rand8 ovf", {31'h0, ovf8}, {31'h0, exp_ovf});
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    cin8   = 1'b0;

    vecs[0] = '{"ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{"1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[2] = '{"8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{"0000+0000+1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{"7fff+7fff+1", 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[5] = '{"0f0f+f0f1", 16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};

    tick();
    tick();
    check_output("reset busy", {31'h0, busy}, 32'h0);
    check_output("reset done", {31'h0, done}, 32'h0);
    check_output("reset sum", {16'h0, sum}, 32'h0);
    check_output("reset cout", {31'h0, cout}, 32'h0);
    check_output("reset ovf", {31'h0, ovf}, 32'h0);
    rst = 1'b0;

    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1 || done8 === 1'b1) done_seen++;
    end
    check_output("idle no done", done_seen, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back: the second start is accepted while the first result sits in DONE.
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat, bc);
    check_output("b2b first latency", lat, 5);
    check_output("b2b first sum", {16'h0, sum}, 32'h8000);
    check_output("b2b first cout", {31'h0, cout}, 32'h0);
    check_output("b2b first ovf", {31'h0, ovf}, 32'h1);
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(lat, bc);
    check_output("b2b second latency", lat, 5);
    check_output("b2b second sum", {16'h0, sum}, 32'hFFFF);
    check_output("b2b second cout", {31'h0, cout}, 32'h1);
    check_output("b2b second ovf", {31'h0, ovf}, 32'h0);
    tick();

    // Start while busy must be ignored and operand changes must not leak in.
    apply_stimulus(16'h1234, 16'h4321, 1'b0);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check_output("ignore start done count", done_seen, 1);
    check_output("ignore start sum", {16'h0, sum}, 32'h5555);
    check_output("ignore start cout", {31'h0, cout}, 32'h0);

    // Reset during the second RUN cycle discards the operation.
    apply_stimulus(16'h00F0, 16'h0F10, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_output("midrun reset busy", {31'h0, busy}, 32'h0);
    check_output("midrun reset done", {31'h0, done}, 32'h0);
    check_output("midrun reset sum", {16'h0, sum}, 32'h0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check_output("midrun reset no done", done_seen, 0);
    run_vec('{"00f0+0f10", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0});

    for (int i = 0; i < 200; i++) begin
      run_rand16(16'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 200; i++) begin
      run_rand8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
